hdlverifier_capture_buffer_ctrl: RTL

Consumer of the capture trigger produced by the trigger-condition block. Continuously records probe samples into a circular buffer once armed. Holds a programmable number of pre-trigger samples and freezes when the post-trigger window completes. Streams the captured window out, oldest sample first, over a valid/ready interface toward the host readout path.

---
 rtl/hdlverifier_capture_buffer_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hdlverifier_capture_buffer_ctrl.sv
// Circular capture buffer: records probe samples once armed, keeps a programmable
// pre-trigger window, freezes after the post-trigger window, then streams it out oldest-first.
module hdlverifier_capture_buffer_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] trigger_pos,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  armed,
  output logic                  triggered,
  output logic                  capture_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LAST_IDX  = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST_FILL,
    READOUT
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] p_reg, wr_ptr, pre_cnt, post_cnt, trig_addr, rd_addr;
  logic [ADDR_WIDTH-1:0] post_init, start_addr;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic                  wr_en, trig_fire, pre_done, post_done;
  logic                  pop, finish, issue, enter_readout;
  logic [1:0]            occ, occ_after;

  // RAM read pipeline: pending marks that mem_q holds the word addressed last cycle.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q, skid_data;
  logic                  pending, pend_last, skid_valid, skid_last;

  assign wr_en     = clk_enable && !arm &&
                     (state == PRE_FILL || state == WAIT_TRIG || state == POST_FILL);
  assign trig_fire = (state == WAIT_TRIG) && clk_enable && trigger && !arm;
  assign pre_done  = (state == PRE_FILL) && clk_enable && (pre_cnt == p_reg - 1'b1);
  assign post_done = (state == POST_FILL) && clk_enable && (post_cnt == 1);
  assign post_init = ADDR_MAX - p_reg;
  // With no post window the trigger cycle itself enters READOUT, before trig_addr is registered.
  assign start_addr = ((state == WAIT_TRIG) ? wr_ptr : trig_addr) - p_reg;

  assign pop       = rd_valid && rd_ready;
  assign finish    = (state == READOUT) && pop && rd_last;
  assign occ       = 2'(rd_valid) + 2'(skid_valid) + 2'(pending);
  assign occ_after = occ - 2'(pop);
  // Only issue a read if the output and skid registers can absorb it next cycle.
  assign issue     = (state == READOUT) && !arm && (issue_cnt < DEPTH_CNT) && (occ_after < 2'd2);
  assign enter_readout = (state != READOUT) && (state_next == READOUT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next   = state;
    armed        = 1'b0;
    capture_done = 1'b0;
    case (state)
      PRE_FILL:  if (pre_done) state_next = WAIT_TRIG;
      WAIT_TRIG: if (trig_fire) state_next = (post_init == 0) ? READOUT : POST_FILL;
      POST_FILL: if (post_done) state_next = READOUT;
      READOUT:   if (finish) state_next = IDLE;
      default:   state_next = state;
    endcase
    if (arm) state_next = (trigger_pos != 0) ? PRE_FILL : WAIT_TRIG;
    armed        = (state == PRE_FILL) || (state == WAIT_TRIG);
    capture_done = (state == READOUT);
  end

  // NOTE: the sample store has no reset; its contents are meaningless until rewritten,
  // and leaving it unreset lets it map onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
    mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg      <= '0;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      rd_addr    <= '0;
      issue_cnt  <= '0;
      triggered  <= 1'b0;
      pending    <= 1'b0;
      pend_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
    end else if (arm) begin
      p_reg      <= trigger_pos;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      issue_cnt  <= '0;
      triggered  <= 1'b0;
      pending    <= 1'b0;
      pend_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (state == PRE_FILL && clk_enable) pre_cnt <= pre_cnt + 1'b1;
      if (state == POST_FILL && clk_enable) post_cnt <= post_cnt - 1'b1;
      if (trig_fire) begin
        trig_addr <= wr_ptr;
        triggered <= 1'b1;
        post_cnt  <= post_init;
      end
      if (finish) triggered <= 1'b0;

      if (enter_readout) begin
        rd_addr   <= start_addr;
        issue_cnt <= '0;
      end else if (issue) begin
        rd_addr   <= rd_addr + 1'b1;
        issue_cnt <= issue_cnt + 1'b1;
      end
      pending   <= issue;
      pend_last <= issue && (issue_cnt == LAST_IDX);

      // Output register refills from the skid first, so beats stay in order without bubbles.
      if (pop) begin
        if (skid_valid) begin
          rd_data    <= skid_data;
          rd_last    <= skid_last;
          rd_valid   <= 1'b1;
          skid_valid <= pending;
          skid_data  <= mem_q;
          skid_last  <= pend_last;
        end else if (pending) begin
          rd_data  <= mem_q;
          rd_last  <= pend_last;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end else if (pending) begin
        if (rd_valid) begin
          skid_data  <= mem_q;
          skid_last  <= pend_last;
          skid_valid <= 1'b1;
        end else begin
          rd_data  <= mem_q;
          rd_last  <= pend_last;
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule
